mips_mc_ctrl: RTL and testbench

- Multicycle MIPS main control FSM, directly upstream of the ALU decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects and write enables.
- Drives aluop[1:0] into the ALU decoder with these codes: 00 = add, 01 = sub, 10 = decode funct.
- Memory accesses stall on a mem_ready handshake.

---
 rtl/mips_mc_ctrl.sv | 146 ++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives datapath controls.
module mips_mc_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;

  logic [3:0] state_q, state_d;
  logic       pcwrite_c, branch_c, memwrite_c;
  logic       irwrite_c, regwrite_c, illegal_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    illegal_c  = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite_c = mem_ready;
        pcwrite_c = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):    state_d = S_MEMADR;
          (op == OP_RTYPE): state_d = S_RTYPEEX;
          (op == OP_BEQ):   state_d = S_BEQEX;
          (op == OP_ADDI):  state_d = S_ADDIEX;
          (op == OP_J):     state_d = S_JEX;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_c = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite_c = 1'b1;
      S_JEX: begin
        pcsrc     = 2'b10;
        pcwrite_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by reset_n so nothing fires while reset is held.
  assign pcwrite  = pcwrite_c  & reset_n;
  assign branch   = branch_c   & reset_n;
  assign memwrite = memwrite_c & reset_n;
  assign irwrite  = irwrite_c  & reset_n;
  assign regwrite = regwrite_c & reset_n;
  assign illegal  = illegal_c  & reset_n;
  assign state    = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed scoreboard bench for mips_mc_ctrl.
// Expected per-cycle control vectors are queued, then popped against the DUT.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pw, br, iord, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs, aop;
    logic       ill;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, branch, iord, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int   total = 0;
  int   bad = 0;
  vec_t sb[$];

  always #5 clk = ~clk;

  mips_mc_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op       (op),
    .mem_ready(mem_ready),
    .pcwrite  (pcwrite),
    .branch   (branch),
    .iord     (iord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .illegal  (illegal),
    .state    (state)
  );

  function automatic vec_t expv(input logic [3:0] s, input logic mr,
                                input logic rst, input logic ill);
    vec_t e;
    e    = '0;
    e.st = s;
    case (s)
      4'd0: begin
        e.asb = 2'b01;
        e.pw  = mr & ~rst;
        e.irw = mr & ~rst;
      end
      4'd1:  e.asb = 2'b11;
      4'd2:  begin e.asa = 1'b1; e.asb = 2'b10; end
      4'd3:  e.iord = 1'b1;
      4'd4:  begin e.m2r = 1'b1; e.rw = 1'b1; end
      4'd5:  begin e.iord = 1'b1; e.mw = 1'b1; end
      4'd6:  begin e.asa = 1'b1; e.aop = 2'b10; end
      4'd7:  begin e.rdst = 1'b1; e.rw = 1'b1; end
      4'd8:  begin
        e.asa = 1'b1; e.aop = 2'b01;
        e.pcs = 2'b01; e.br = 1'b1;
      end
      4'd9:  begin e.asa = 1'b1; e.asb = 2'b10; end
      4'd10: e.rw = 1'b1;
      4'd11: begin e.pcs = 2'b10; e.pw = 1'b1; end
      default: e = '0;
    endcase
    e.ill = ill;
    return e;
  endfunction

  task automatic step(input logic [5:0] o, input logic mr, input logic rn,
                      input logic [3:0] es, input logic ill, input string tag);
    vec_t a, e;
    @(negedge clk);
    op        = o;
    mem_ready = mr;
    reset_n   = rn;
    sb.push_back(expv(es, mr, ~rn, ill));
    #1;
    a = '{state, pcwrite, branch, iord, memwrite, irwrite, memtoreg,
          regdst, regwrite, alusrca, alusrcb, pcsrc, aluop, illegal};
    e = sb.pop_front();
    total++;
    assert (a.st === e.st) else begin
      bad++;
      $error("FAIL %s state: got %0d want %0d", tag, a.st, e.st);
    end
    total++;
    assert (a === e) else begin
      bad++;
      $error("FAIL %s ctrl: got %h want %h", tag, a, e);
    end
    total++;
    assert (aluop !== 2'b11) else begin
      bad++;
      $error("FAIL %s aluop11: got %b want !=11", tag, aluop);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    op        = 6'h00;
    mem_ready = 1'b1;
    step(6'h00, 1, 0, 4'd0, 0, "rst0");
    step(6'h00, 1, 0, 4'd0, 0, "rst1");
    step(6'h00, 1, 0, 4'd0, 0, "rst2");
    // R-type
    step(6'h00, 1, 1, 4'd0, 0, "r_f");
    step(6'h00, 1, 1, 4'd1, 0, "r_d");
    step(6'h00, 1, 1, 4'd6, 0, "r_ex");
    step(6'h00, 1, 1, 4'd7, 0, "r_wb");
    // LW, two memory wait states
    step(6'h23, 1, 1, 4'd0, 0, "lw_f");
    step(6'h23, 1, 1, 4'd1, 0, "lw_d");
    step(6'h23, 1, 1, 4'd2, 0, "lw_ma");
    step(6'h23, 0, 1, 4'd3, 0, "lw_rd0");
    step(6'h23, 0, 1, 4'd3, 0, "lw_rd1");
    step(6'h23, 1, 1, 4'd3, 0, "lw_rd2");
    step(6'h23, 1, 1, 4'd4, 0, "lw_wb");
    // SW, one memory wait state
    step(6'h2B, 1, 1, 4'd0, 0, "sw_f");
    step(6'h2B, 1, 1, 4'd1, 0, "sw_d");
    step(6'h2B, 1, 1, 4'd2, 0, "sw_ma");
    step(6'h2B, 0, 1, 4'd5, 0, "sw_wr0");
    step(6'h2B, 1, 1, 4'd5, 0, "sw_wr1");
    // BEQ then J
    step(6'h04, 1, 1, 4'd0, 0, "beq_f");
    step(6'h04, 1, 1, 4'd1, 0, "beq_d");
    step(6'h04, 1, 1, 4'd8, 0, "beq_ex");
    step(6'h02, 1, 1, 4'd0, 0, "j_f");
    step(6'h02, 1, 1, 4'd1, 0, "j_d");
    step(6'h02, 1, 1, 4'd11, 0, "j_ex");
    // ADDI; op changes after DECODE must be ignored
    step(6'h08, 1, 1, 4'd0, 0, "ad_f");
    step(6'h08, 1, 1, 4'd1, 0, "ad_d");
    step(6'h3F, 1, 1, 4'd9, 0, "ad_ex");
    step(6'h23, 1, 1, 4'd10, 0, "ad_wb");
    // fetch stall, then illegal opcode
    step(6'h3F, 0, 1, 4'd0, 0, "il_fw");
    step(6'h3F, 1, 1, 4'd0, 0, "il_f");
    step(6'h3F, 1, 1, 4'd1, 1, "il_d");
    step(6'h3F, 1, 1, 4'd0, 0, "il_post");
    // reset while stalled in MEMWR
    step(6'h2B, 1, 1, 4'd1, 0, "rs_d");
    step(6'h2B, 1, 1, 4'd2, 0, "rs_ma");
    step(6'h2B, 0, 1, 4'd5, 0, "rs_wr");
    step(6'h2B, 0, 0, 4'd0, 0, "rs_hit");
    step(6'h2B, 1, 0, 4'd0, 0, "rs_hold");
    step(6'h2B, 1, 1, 4'd0, 0, "rs_f");
    step(6'h2B, 1, 1, 4'd1, 0, "rs_d2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
